neuron_param_loader: RTL

- Parametrised serial loader for per-neuron weights, bias and threshold for the neuron array.
- Words arrive one per valid/ready handshake on a narrow bus and shift into a staging chain.
- After a complete frame, the staging chain is committed atomically to a live bank that drives the neurons.
- The live bank stays stable throughout loading. Aborts, restarts and (optionally) checksum failures never disturb it.

---
 rtl/neuron_param_loader.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/neuron_param_loader.sv
// -----------------------------------------------------------------------------
// neuron_param_loader
//
// Serial loader for the per-neuron weights, bias and threshold of the neuron
// array. Words arrive one per valid/ready handshake and shift into a staging
// chain. A complete frame is copied atomically into the live bank that drives
// the neurons. Aborts and restarts never touch the live bank.
//
// Word layout: k = n*WPN + j
//   j <  NUM_INPUTS   : weight w[n][j]
//   j == NUM_INPUTS   : bias
//   j == NUM_INPUTS+1 : threshold
// The first word of a frame ends up at k=0 and the last word at k=TOTAL-1.
//
// Optional feature (macro PARAM_CHECKSUM_EN): after the TOTAL payload words,
// one more word is accepted. It must equal the mod-2^DATA_W sum of the
// payload. A mismatch drops the frame and pulses load_error.
//
// Ports:
//   clk         clock
//   reset       synchronous, active-high reset
//   load_start  begin or restart a frame load
//   abort       cancel the load in progress
//   data_in     parameter word
//   data_valid  data_in valid
//   data_ready  loader accepts a word this cycle (combinational)
//   params_out  live bank; word k at [k*DATA_W +: DATA_W]
//   word_count  words accepted in the current frame
//   load_busy   high in LOAD/CHECK/COMMIT
//   load_done   one-cycle pulse after a commit
//   load_error  one-cycle pulse on checksum mismatch (0 without the feature)
// -----------------------------------------------------------------------------
module neuron_param_loader #(
  parameter int DATA_W      = 8,
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 4,
  localparam int WPN        = NUM_INPUTS + 2,
  localparam int TOTAL      = NUM_NEURONS * WPN,
  localparam int CNT_W      = $clog2(TOTAL + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load_start,
  input  logic                    abort,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic [TOTAL*DATA_W-1:0] params_out,
  output logic [CNT_W-1:0]        word_count,
  output logic                    load_busy,
  output logic                    load_done,
  output logic                    load_error
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TOTAL);

`ifdef PARAM_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd3
  } state_t;
`endif

  state_t                  state_r;
  state_t                  next_state_s;
  logic [TOTAL*DATA_W-1:0] staging_r;
  logic [TOTAL*DATA_W-1:0] live_r;
  logic [CNT_W-1:0]        word_count_r;
  logic                    load_busy_r;
  logic                    load_done_r;

  logic                    loading_s;
  logic                    data_ready_s;
  logic                    accept_s;
  logic                    last_word_s;
  logic                    shift_s;
  logic                    start_s;
  logic                    clear_s;
  logic                    commit_s;
  logic                    chk_fail_s;

`ifdef PARAM_CHECKSUM_EN
  logic [DATA_W-1:0]       sum_r;
  logic                    sum_match_s;
  logic                    load_error_r;

  // Running checksum: plain modular add, carries out of DATA_W are dropped.
  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign loading_s   = (state_r == ST_LOAD) || (state_r == ST_CHECK);
  assign sum_match_s = (data_in == sum_r);
`else
  assign loading_s   = (state_r == ST_LOAD);
`endif

  // abort and load_start take priority over data, so no word is taken then.
  assign data_ready_s = loading_s && !load_start && !abort;
  assign accept_s     = data_valid && data_ready_s;
  assign last_word_s  = (word_count_r == LAST_CNT);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic: abort > load_start > data accept while loading.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (load_start) next_state_s = ST_LOAD;
        else            next_state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort)                         next_state_s = ST_IDLE;
        else if (load_start)               next_state_s = ST_LOAD;
`ifdef PARAM_CHECKSUM_EN
        else if (accept_s && last_word_s)  next_state_s = ST_CHECK;
`else
        else if (accept_s && last_word_s)  next_state_s = ST_COMMIT;
`endif
        else                               next_state_s = ST_LOAD;
      end
`ifdef PARAM_CHECKSUM_EN
      ST_CHECK: begin
        if (abort)                         next_state_s = ST_IDLE;
        else if (load_start)               next_state_s = ST_LOAD;
        else if (accept_s && sum_match_s)  next_state_s = ST_COMMIT;
        else if (accept_s)                 next_state_s = ST_IDLE;
        else                               next_state_s = ST_CHECK;
      end
`endif
      ST_COMMIT: next_state_s = ST_IDLE;
      default:   next_state_s = ST_IDLE;
    endcase
  end

  // Output decode: datapath strobes for the current state and inputs.
  always_comb begin
    shift_s    = 1'b0;
    start_s    = 1'b0;
    clear_s    = 1'b0;
    commit_s   = 1'b0;
    chk_fail_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (load_start) start_s = 1'b1;
        else            start_s = 1'b0;
      end
      ST_LOAD: begin
        if (abort)           clear_s = 1'b1;
        else if (load_start) start_s = 1'b1;
        else if (accept_s)   shift_s = 1'b1;
        else                 shift_s = 1'b0;
      end
`ifdef PARAM_CHECKSUM_EN
      ST_CHECK: begin
        if (abort)                         clear_s    = 1'b1;
        else if (load_start)               start_s    = 1'b1;
        else if (accept_s && !sum_match_s) chk_fail_s = 1'b1;
        else                               chk_fail_s = 1'b0;
      end
`endif
      ST_COMMIT: commit_s = 1'b1;
      default:   clear_s  = 1'b1;
    endcase
  end

  // Datapath: staging shift, word counter, live bank and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      staging_r    <= {(TOTAL*DATA_W){1'b0}};
      live_r       <= {(TOTAL*DATA_W){1'b0}};
      word_count_r <= {CNT_W{1'b0}};
      load_busy_r  <= 1'b0;
      load_done_r  <= 1'b0;
    end else begin
      // New words enter at the top (k=TOTAL-1) and move toward k=0.
      if (shift_s) staging_r <= {data_in, staging_r[TOTAL*DATA_W-1:DATA_W]};

      if (start_s || clear_s || commit_s || chk_fail_s)
        word_count_r <= {CNT_W{1'b0}};
      else if (shift_s && (word_count_r != FULL_CNT))
        word_count_r <= word_count_r + CNT_W'(1);

      if (commit_s) live_r <= staging_r;

      load_busy_r <= (next_state_s != ST_IDLE);
      load_done_r <= commit_s;
    end
  end

`ifdef PARAM_CHECKSUM_EN
  // Checksum accumulator and mismatch pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sum_r        <= {DATA_W{1'b0}};
      load_error_r <= 1'b0;
    end else begin
      if (start_s)      sum_r <= {DATA_W{1'b0}};
      else if (shift_s) sum_r <= csum_add(sum_r, data_in);
      load_error_r <= chk_fail_s;
    end
  end

  assign load_error = load_error_r;
`else
  assign load_error = 1'b0;
`endif

  assign data_ready = data_ready_s;
  assign params_out = live_r;
  assign word_count = word_count_r;
  assign load_busy  = load_busy_r;
  assign load_done  = load_done_r;

endmodule
